// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM fader: FSM encodings and register-map helpers.
package pdm_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // The prescaler register sits directly after the per-channel target registers.
    function automatic int unsigned prescaler_addr(input int unsigned channel_num);
        return channel_num;
    endfunction

endpackage

// File: rtl/pdm_step_divider.sv
// Step-rate divider: pulses tick once every prescaler+1 cycles.
module pdm_step_divider #(
    parameter int unsigned PRESCALER_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PRESCALER_WIDTH-1:0] prescaler,
    input  logic                       clear,
    output logic                       tick
);

    logic [PRESCALER_WIDTH-1:0] cnt_q, cnt_d;
    logic                       wrap;

    assign wrap = (cnt_q == prescaler);
    // A prescaler write restarts the period, so no stale tick escapes that cycle.
    assign tick = wrap && !clear;

    always_comb begin
        cnt_d = cnt_q + PRESCALER_WIDTH'(1);
        if (clear || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wbs_pdm_fader.sv
// Wishbone slave holding per-channel target levels; ramps applied levels one LSB per tick
// and pushes each new level to the downstream PDM block over a Wishbone master port.
module wbs_pdm_fader
    import pdm_pkg::*;
#(
    parameter int unsigned BIT_RESOLUTION  = 8,
    parameter int unsigned CHANNEL_NUM     = 4,
    parameter int unsigned PRESCALER_WIDTH = 16,
    parameter int unsigned ADR_WIDTH       = 4,
    parameter int unsigned DATA_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wbs_stb,
    input  logic                  wbs_we,
    input  logic [ADR_WIDTH-1:0]  wbs_adr,
    input  logic [DATA_WIDTH-1:0] wbs_dat_c,
    output logic [DATA_WIDTH-1:0] wbs_dat_p,
    output logic                  wbs_ack,
    output logic                  wbm_stb,
    output logic                  wbm_we,
    output logic [ADR_WIDTH-1:0]  wbm_adr,
    output logic [DATA_WIDTH-1:0] wbm_dat,
    input  logic                  wbm_ack,
    output logic                  busy
);

    localparam int unsigned CH_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam logic [ADR_WIDTH-1:0] PRESC_ADR = ADR_WIDTH'(prescaler_addr(CHANNEL_NUM));
    localparam logic [ADR_WIDTH-1:0] CH_LIMIT  = ADR_WIDTH'(CHANNEL_NUM);
    localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(CHANNEL_NUM - 1);

    logic [BIT_RESOLUTION-1:0]  target_q  [CHANNEL_NUM];
    logic [BIT_RESOLUTION-1:0]  current_q [CHANNEL_NUM];
    logic [PRESCALER_WIDTH-1:0] prescaler_q;

    logic [1:0]                 state_q, state_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic                       pend_q, pend_d;
    logic                       stb_q, stb_d;
    logic [ADR_WIDTH-1:0]       adr_q, adr_d;
    logic [DATA_WIDTH-1:0]      dat_q, dat_d;
    logic                       ack_q;
    logic [DATA_WIDTH-1:0]      rdat_q, rdat_d;

    logic                       wr_en, wr_ch, wr_presc;
    logic                       tick, commit, last_ch;
    logic [BIT_RESOLUTION-1:0]  cur, tgt, step;

    assign wr_en    = wbs_stb && wbs_we;
    assign wr_ch    = wr_en && (wbs_adr < CH_LIMIT);
    assign wr_presc = wr_en && (wbs_adr == PRESC_ADR);

    pdm_step_divider #(
        .PRESCALER_WIDTH(PRESCALER_WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .prescaler(prescaler_q),
        .clear    (wr_presc),
        .tick     (tick)
    );

    always_comb begin
        rdat_d = '0;
        if (wbs_stb) begin
            if (wbs_adr < CH_LIMIT) begin
                rdat_d[BIT_RESOLUTION-1:0] = target_q[wbs_adr[CH_W-1:0]];
            end else if (wbs_adr == PRESC_ADR) begin
                rdat_d[PRESCALER_WIDTH-1:0] = prescaler_q;
            end
        end
    end

    assign cur     = current_q[ch_q];
    assign tgt     = target_q[ch_q];
    assign step    = (tgt > cur) ? cur + BIT_RESOLUTION'(1) : cur - BIT_RESOLUTION'(1);
    assign last_ch = (ch_q == LAST_CH);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        pend_d  = pend_q;
        commit  = 1'b0;
        if (tick) begin
            pend_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                // A tick landing while one is already pending is dropped here.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    ch_d    = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cur == tgt) begin
                    if (last_ch) begin
                        state_d = ST_IDLE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    adr_d   = ADR_WIDTH'(ch_q);
                    dat_d   = DATA_WIDTH'(step);
                    stb_d   = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wbm_ack) begin
                    commit = 1'b1;
                    stb_d  = 1'b0;
                    if (last_ch) begin
                        state_d = ST_IDLE;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            default: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                target_q[i]  <= '0;
                current_q[i] <= '0;
            end
            prescaler_q <= '0;
        end else begin
            if (wr_ch) begin
                target_q[wbs_adr[CH_W-1:0]] <= wbs_dat_c[BIT_RESOLUTION-1:0];
            end
            if (wr_presc) begin
                prescaler_q <= wbs_dat_c[PRESCALER_WIDTH-1:0];
            end
            if (commit) begin
                current_q[ch_q] <= dat_q[BIT_RESOLUTION-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            pend_q  <= 1'b0;
            stb_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ack_q   <= wbs_stb;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            busy = busy | (current_q[i] != target_q[i]);
        end
    end

    assign wbs_ack   = ack_q;
    assign wbs_dat_p = rdat_q;
    assign wbm_stb   = stb_q;
    assign wbm_we    = 1'b1;
    assign wbm_adr   = adr_q;
    assign wbm_dat   = dat_q;

endmodule

// File: tb/tb_wbs_pdm_fader.sv
// Directed bench for wbs_pdm_fader with a small PDM-side responder and write log.
module tb_wbs_pdm_fader;

    logic        clk;
    logic        rst;
    logic        wbs_stb;
    logic        wbs_we;
    logic [3:0]  wbs_adr;
    logic [15:0] wbs_dat_c;
    logic [15:0] wbs_dat_p;
    logic        wbs_ack;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_adr;
    logic [15:0] wbm_dat;
    logic        wbm_ack;
    logic        busy;

    int n_checks;
    int n_fail;
    int cyc;
    logic stall_en;

    logic [3:0]  log_adr [$];
    logic [15:0] log_dat [$];
    int          log_cyc [$];

    wbs_pdm_fader #(
        .BIT_RESOLUTION (8),
        .CHANNEL_NUM    (4),
        .PRESCALER_WIDTH(16),
        .ADR_WIDTH      (4),
        .DATA_WIDTH     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wbs_stb  (wbs_stb),
        .wbs_we   (wbs_we),
        .wbs_adr  (wbs_adr),
        .wbs_dat_c(wbs_dat_c),
        .wbs_dat_p(wbs_dat_p),
        .wbs_ack  (wbs_ack),
        .wbm_stb  (wbm_stb),
        .wbm_we   (wbm_we),
        .wbm_adr  (wbm_adr),
        .wbm_dat  (wbm_dat),
        .wbm_ack  (wbm_ack),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PDM responder: acks one cycle after stb unless stalled.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbm_ack <= 1'b0;
        end else begin
            wbm_ack <= wbm_stb && !wbm_ack && !stall_en;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && wbm_stb && wbm_ack) begin
            log_adr.push_back(wbm_adr);
            log_dat.push_back(wbm_dat);
            log_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_adr.delete();
        log_dat.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        wbs_stb = 1'b0;
        wbs_we = 1'b0;
        stall_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_log();
    endtask

    task automatic bus_access(input logic we, input logic [3:0] adr, input logic [15:0] wdat,
                              output logic [15:0] rdat, output logic ack_pre,
                              output logic ack_post);
        @(negedge clk);
        wbs_stb = 1'b1;
        wbs_we = we;
        wbs_adr = adr;
        wbs_dat_c = wdat;
        #1 ack_pre = wbs_ack;
        @(negedge clk);
        ack_post = wbs_ack;
        rdat = wbs_dat_p;
        wbs_stb = 1'b0;
        wbs_we = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && !wbm_stb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int stb_cnt;
        rst = 1'b0;
        wbs_stb = 1'b0;
        wbs_we = 1'b0;
        wbs_adr = '0;
        wbs_dat_c = '0;
        stall_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({wbs_ack, wbs_dat_p, wbm_stb, wbm_adr, wbm_dat, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b dat_p=%h stb=%b adr=%h dat=%h busy=%b, want all 0",
                     wbs_ack, wbs_dat_p, wbm_stb, wbm_adr, wbm_dat, busy);
        end
        n_checks++;
        if (wbm_we !== 1'b1) begin
            n_fail++;
            $display("FAIL wbm_we_const: got %b want 1", wbm_we);
        end
        rst = 1'b1;
        clear_log();
        stb_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wbm_stb || busy) stb_cnt++;
        end
        n_checks++;
        if (stb_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_idle: %0d cycles with stb/busy, want 0", stb_cnt);
        end
        n_checks++;
        if ({wbs_ack, wbs_dat_p, wbm_adr, wbm_dat} !== '0) begin
            n_fail++;
            $display("FAIL after_reset_outputs: ack=%b dat_p=%h adr=%h dat=%h, want 0",
                     wbs_ack, wbs_dat_p, wbm_adr, wbm_dat);
        end
    endtask

    task automatic test_single_ramp();
        logic [15:0] rd;
        logic ap, aq;
        bit ok;
        bus_access(1'b1, 4'd1, 16'd3, rd, ap, aq);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_busy: got %b want 1", busy);
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ramp_timeout: got busy=%b want 0 within 200 cycles", busy);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (log_adr.size() != 3) begin
            n_fail++;
            $display("FAIL ramp_count: got %0d writes want 3", log_adr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (log_adr[i] !== 4'd1 || log_dat[i] !== 16'(i + 1)) begin
                    n_fail++;
                    $display("FAIL ramp_write%0d: got adr=%0d dat=%0d want adr=1 dat=%0d",
                             i, log_adr[i], log_dat[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_down_ramp();
        logic [15:0] rd;
        logic ap, aq;
        bit ok;
        clear_log();
        bus_access(1'b1, 4'd4, 16'd9, rd, ap, aq);
        bus_access(1'b1, 4'd1, 16'd1, rd, ap, aq);
        wait_done(500, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL down_timeout: got busy=%b want 0 within 500 cycles", busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (log_adr.size() != 2) begin
            n_fail++;
            $display("FAIL down_count: got %0d writes want 2", log_adr.size());
        end else begin
            n_checks++;
            if (log_adr[0] !== 4'd1 || log_dat[0] !== 16'd2 ||
                log_adr[1] !== 4'd1 || log_dat[1] !== 16'd1) begin
                n_fail++;
                $display("FAIL down_values: got (%0d,%0d) (%0d,%0d) want (1,2) (1,1)",
                         log_adr[0], log_dat[0], log_adr[1], log_dat[1]);
            end
            n_checks++;
            if (log_cyc[1] - log_cyc[0] < 10) begin
                n_fail++;
                $display("FAIL down_rate: got spacing %0d cycles want >= 10",
                         log_cyc[1] - log_cyc[0]);
            end
        end
    endtask

    task automatic test_multi_channel();
        logic [15:0] rd;
        logic ap, aq;
        bit ok;
        int exp_adr[5] = '{0, 2, 3, 0, 3};
        int exp_dat[5] = '{1, 1, 1, 2, 2};
        int tg[4] = '{2, 0, 1, 2};
        do_reset();
        bus_access(1'b1, 4'd4, 16'hFFFF, rd, ap, aq);
        repeat (10) @(negedge clk);
        clear_log();
        for (int i = 0; i < 4; i++) bus_access(1'b1, 4'(i), 16'(tg[i]), rd, ap, aq);
        repeat (5) @(negedge clk);
        n_checks++;
        if (log_adr.size() != 0) begin
            n_fail++;
            $display("FAIL multi_hold: got %0d writes before rate set want 0", log_adr.size());
        end
        bus_access(1'b1, 4'd4, 16'd0, rd, ap, aq);
        wait_done(300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL multi_timeout: got busy=%b want 0 within 300 cycles", busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (log_adr.size() != 5) begin
            n_fail++;
            $display("FAIL multi_count: got %0d writes want 5", log_adr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (log_adr[i] !== 4'(exp_adr[i]) || log_dat[i] !== 16'(exp_dat[i])) begin
                    n_fail++;
                    $display("FAIL multi_write%0d: got adr=%0d dat=%0d want adr=%0d dat=%0d",
                             i, log_adr[i], log_dat[i], exp_adr[i], exp_dat[i]);
                end
            end
        end
    endtask

    task automatic test_readback();
        logic [15:0] rd;
        logic ap, aq;
        logic [3:0]  radr[4] = '{4'd2, 4'd4, 4'd5, 4'd15};
        logic [15:0] rexp[4] = '{16'h00AB, 16'h1234, 16'h0000, 16'h0000};
        do_reset();
        bus_access(1'b1, 4'd4, 16'h1234, rd, ap, aq);
        bus_access(1'b1, 4'd2, 16'h55AB, rd, ap, aq);
        n_checks++;
        if (ap !== 1'b0 || aq !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ack: got pre=%b post=%b want pre=0 post=1", ap, aq);
        end
        bus_access(1'b1, 4'd5, 16'hBEEF, rd, ap, aq);
        for (int i = 0; i < 4; i++) begin
            bus_access(1'b0, radr[i], 16'h0, rd, ap, aq);
            n_checks++;
            if (rd !== rexp[i] || ap !== 1'b0 || aq !== 1'b1) begin
                n_fail++;
                $display("FAIL read_adr%0d: got dat=%h ack pre/post=%b/%b want dat=%h 0/1",
                         radr[i], rd, ap, aq, rexp[i]);
            end
        end
    endtask

    task automatic test_top_boundary();
        logic [15:0] rd;
        logic ap, aq;
        bit ok;
        int bad;
        do_reset();
        bus_access(1'b1, 4'd3, 16'hFFFF, rd, ap, aq);
        bus_access(1'b0, 4'd3, 16'h0, rd, ap, aq);
        n_checks++;
        if (rd !== 16'h00FF) begin
            n_fail++;
            $display("FAIL top_readback: got %h want 00ff", rd);
        end
        wait_done(3000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL top_timeout: got busy=%b want 0 within 3000 cycles", busy);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (log_adr.size() != 255) begin
            n_fail++;
            $display("FAIL top_count: got %0d writes want 255", log_adr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 255; i++) begin
                if (log_adr[i] !== 4'd3 || log_dat[i] !== 16'(i + 1)) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL top_sequence: got %0d bad writes want 0 (last dat=%h)",
                         bad, log_dat[254]);
            end
        end
    endtask

    task automatic test_stall_reset();
        logic [15:0] rd;
        logic ap, aq;
        logic [3:0]  s_adr;
        logic [15:0] s_dat;
        bit seen;
        int unstable;
        do_reset();
        stall_en = 1'b1;
        bus_access(1'b1, 4'd0, 16'd5, rd, ap, aq);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wbm_stb) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL stall_start: got stb=%b want 1 within 50 cycles", wbm_stb);
        end
        s_adr = wbm_adr;
        s_dat = wbm_dat;
        n_checks++;
        if (s_adr !== 4'd0 || s_dat !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_first: got adr=%0d dat=%0d want adr=0 dat=1", s_adr, s_dat);
        end
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wbm_stb !== 1'b1 || wbm_adr !== s_adr || wbm_dat !== s_dat) unstable++;
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (wbm_stb !== 1'b0 || busy !== 1'b0 || wbm_dat !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_async_reset: got stb=%b busy=%b dat=%h want 0 0 0",
                     wbm_stb, busy, wbm_dat);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stall_en = 1'b0;
        clear_log();
        for (int i = 0; i < 5; i++) begin
            bus_access(1'b0, 4'(i), 16'h0, rd, ap, aq);
            n_checks++;
            if (rd !== 16'h0) begin
                n_fail++;
                $display("FAIL post_reset_read%0d: got %h want 0", i, rd);
            end
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (log_adr.size() != 0 || busy !== 1'b0 || wbm_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL no_retry: got %0d writes busy=%b stb=%b want 0 0 0",
                     log_adr.size(), busy, wbm_stb);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        test_reset();
        test_single_ramp();
        test_down_ramp();
        test_multi_channel();
        test_readback();
        test_top_boundary();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
